// File: rtl/rand_range_sampler.sv
// Converts a free-running LFSR word into an unbiased integer in [0, range) by
// masked rejection sampling, with a bounded-retry fallback and a req/ack + valid/ready interface.
module rand_range_sampler #(
  parameter int WIDTH     = 16,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lfsr_q,
  input  logic             req,
  output logic             req_ready,
  input  logic [WIDTH-1:0] range,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             fallback,
  output logic             err,
  output logic [15:0]      reject_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [7:0]       tries_q, tries_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             fallback_q, fallback_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      reject_count_q, reject_count_d;

  logic [WIDTH-1:0] range_mask;
  logic [WIDTH-1:0] sample_s;

  // Smallest 2^k-1 covering range-1: smear the top set bit of (range-1) downwards.
  always_comb begin
    range_mask = range - WIDTH'(1);
    for (int sh = 1; sh <= WIDTH / 2; sh = sh * 2) begin
      range_mask = range_mask | (range_mask >> sh);
    end
  end

  assign sample_s = lfsr_q & mask_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    n_d            = n_q;
    mask_d         = mask_q;
    tries_d        = tries_q;
    value_d        = value_q;
    fallback_d     = fallback_q;
    err_d          = err_q;
    out_valid_d    = out_valid_q;
    reject_count_d = reject_count_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          n_d     = range;
          mask_d  = range_mask;
          tries_d = 8'd0;
          if (range == '0) begin
            value_d     = '0;
            fallback_d  = 1'b0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (sample_s < n_q) begin
          value_d     = sample_s;
          fallback_d  = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          if (reject_count_q != 16'hFFFF) begin
            reject_count_d = reject_count_q + 16'd1;
          end
          if (tries_q == LAST_TRY) begin
            // sample_s <= mask <= 2n-1, so the folded value stays below n.
            value_d     = sample_s - n_q;
            fallback_d  = 1'b1;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            tries_d = tries_q + 8'd1;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      n_q            <= '0;
      mask_q         <= '0;
      tries_q        <= 8'd0;
      value_q        <= '0;
      fallback_q     <= 1'b0;
      err_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      reject_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      mask_q         <= mask_d;
      tries_q        <= tries_d;
      value_q        <= value_d;
      fallback_q     <= fallback_d;
      err_q          <= err_d;
      out_valid_q    <= out_valid_d;
      reject_count_q <= reject_count_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign value        = value_q;
  assign fallback     = fallback_q;
  assign err          = err_q;
  assign reject_count = reject_count_q;

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Sits directly downstream of the 16-bit LFSR and consumes its free-running state word every clock.
- Converts that word into an unbiased integer in [0, range) using masked rejection sampling, with a bounded-retry fallback.
- Returns the result over a req/ack and valid/ready handshake to game/control logic.
- Keeps a saturating reject counter for bring-up and debug.

Parameters:
- WIDTH, 16: width of the LFSR word, range and result.
- MAX_TRIES, 8: number of rejected samples tolerated before fallback. Legal values are 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- lfsr_q  in  WIDTH  current LFSR state word; changes every cycle.
- req  in  1  request a new sample.
- req_ready  out  1  high when a request can be accepted (state IDLE).
- range  in  WIDTH  upper bound n (exclusive); sampled only on request acceptance.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- value  out  WIDTH  sampled result, always < n when err = 0.
- fallback  out  1  result produced by the fallback path, not by acceptance.
- err  out  1  request had n = 0.
- reject_count  out  16  total rejected samples since reset; saturates at 0xFFFF.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; out_valid, value, fallback, err = 0.
  - reject_count = 0; internal n, mask and tries = 0.
  - req_ready = 1 once reset is released.
  - Reset mid-operation aborts the request. No output is produced for it.
- States are IDLE, SAMPLE and HOLD.
- IDLE:
  - req_ready = 1.
  - On an edge with req = 1, latch n = range and mask, then set tries = 0.
  - mask is the smallest (2^k − 1) that is ≥ n − 1, computed by the OR-shift cascade m | m>>1 | m>>2 | … (m = n − 1, shifts up to WIDTH/2).
  - If range = 0: go to HOLD with err = 1, value = 0, fallback = 0.
  - Otherwise go to SAMPLE.
- SAMPLE:
  - req_ready = 0. On each edge, s = lfsr_q & mask.
  - If s < n: value = s, fallback = 0, err = 0, go to HOLD.
  - Else, if tries = MAX_TRIES − 1: value = s − n, fallback = 1, go to HOLD. Since s ≤ 2n − 1, this value is < n.
  - Else: tries = tries + 1, stay in SAMPLE.
  - Every rejection, including the one that triggers fallback, increments reject_count unless it is already 0xFFFF.
- HOLD:
  - out_valid = 1; value, fallback and err are held stable.
  - On an edge with out_ready = 1, clear out_valid and go to IDLE.
  - req is ignored in HOLD and SAMPLE; it is not queued.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency:
  - Best case: out_valid rises 2 edges after the accepting edge (accept edge → SAMPLE edge).
  - Worst case: MAX_TRIES + 1 edges.
  - err path: 1 edge.
- n = 1: mask = 0, so s = 0 is always accepted on the first SAMPLE edge.
- n = 2^WIDTH − 1 (all ones): mask is all ones; a sample equal to n is rejected.
- Range changes after acceptance have no effect.
- lfsr_q is sampled only in SAMPLE; its value in IDLE and HOLD is don't-care.

Test Plan:
- **Single accept:** range = 6, lfsr_q = 0x0003 during SAMPLE → mask = 7, out_valid 2 edges after accept, value = 3, fallback = 0, reject_count = 0.
- **Rejections:** range = 6, lfsr_q = 0x0007, 0x0006, 0x0002 on successive SAMPLE edges → value = 2, reject_count = 2, out_valid on the 4th edge after accept.
- **Fallback:** MAX_TRIES = 4, range = 5, lfsr_q held at 0x000F → 4 rejections, value = 2, fallback = 1, reject_count = 4.
- **Edge ranges:**
  - range = 0 → err = 1, value = 0, out_valid 1 edge after accept.
  - range = 1 with lfsr_q = 0xFFFF → value = 0, err = 0.
- **Backpressure and ignored req:** out_ready held low for 3 cycles with req pulsed during HOLD → value is stable, no second request is accepted, req_ready = 1 the cycle after out_ready = 1.
- **Async reset:** drive reset = 0 mid-SAMPLE between clock edges → out_valid = 0 and reject_count = 0 immediately; IDLE with req_ready = 1 after release.
